// File: rtl/wbscope_pkg.sv
// Shared types and register constants for the wbscope capture reader.
package wbscope_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRstWr,
    StArmWr,
    StWaitTrig,
    StRdBus,
    StRdOut
  } wbscope_state_e;

  localparam logic        AddrCtrl    = 1'b0;
  localparam logic        AddrData    = 1'b1;
  localparam logic [31:0] CtrlReset   = 32'h0000_0000;
  localparam logic [31:0] CtrlNoReset = 32'h8000_0000;

  // Control word that re-arms the scope without resetting it.
  function automatic logic [31:0] arm_word(input logic [19:0] holdoff);
    return CtrlNoReset | {12'h0, holdoff};
  endfunction

endpackage

// File: rtl/wbscope_reader_if.sv
// Wishbone master and sample-stream signals between the reader and the scope/sink side.
interface wbscope_reader_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic        o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;
  logic        i_scope_int;
  logic        o_sample_valid;
  logic [31:0] o_sample;
  logic        o_sample_last;
  logic        i_sample_ready;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_ack, i_wb_stall, i_wb_data, i_scope_int,
    output o_sample_valid, o_sample, o_sample_last,
    input  i_sample_ready
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_ack, i_wb_stall, i_wb_data, i_scope_int,
    input  o_sample_valid, o_sample, o_sample_last,
    output i_sample_ready
  );
endinterface

// File: rtl/wbscope_wbm_single.sv
// Single outstanding Wishbone transaction: strobe until accepted, cycle until acked.
module wbscope_wbm_single (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        abort_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [31:0] data_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic        wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  input  logic [31:0] wb_data_i
);

  logic        cyc_d, cyc_q;
  logic        stb_d, stb_q;
  logic        we_d, we_q;
  logic        addr_d, addr_q;
  logic [31:0] data_d, data_q;

  always_comb begin
    cyc_d  = cyc_q;
    stb_d  = stb_q;
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    if (abort_i) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end else if (cyc_q) begin
      if (!wb_stall_i) stb_d = 1'b0;
      if (wb_ack_i) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    end else if (req_i) begin
      cyc_d  = 1'b1;
      stb_d  = 1'b1;
      we_d   = we_i;
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= 1'b0;
      data_q <= 32'h0;
    end else begin
      cyc_q  <= cyc_d;
      stb_q  <= stb_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Acks outside a cycle are ignored; done is seen in the ack cycle itself.
  assign done_o    = cyc_q & wb_ack_i & ~abort_i;
  assign rdata_o   = wb_data_i;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_data_o = data_q;

endmodule

// File: rtl/wbscope_reader.sv
// Resets and arms a wbscope, waits for its trigger, then streams out the captured buffer.
module wbscope_reader
  import wbscope_pkg::*;
#(
  parameter int unsigned LGMEM   = 6,
  parameter logic [19:0] HOLDOFF = 20'd16,
  parameter logic [31:0] TIMEOUT = 32'd0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  wbscope_reader_if.master bus
);

  localparam logic [LGMEM-1:0] LastIdx = '1;

  wbscope_state_e   state_q;
  logic [LGMEM-1:0] rd_cnt_q;
  logic [31:0]      tmo_cnt_q;
  logic [31:0]      sample_q;
  logic             sample_valid_q, sample_last_q, done_q, err_q;

  logic        abort;
  logic        req, we, addr;
  logic [31:0] wdata, rdata;
  logic        wb_done;

  assign abort = i_abort & (state_q != StIdle);

  always_comb begin
    req   = 1'b0;
    we    = 1'b0;
    addr  = AddrCtrl;
    wdata = 32'h0;
    unique case (state_q)
      StRstWr: begin
        req   = 1'b1;
        we    = 1'b1;
        wdata = CtrlReset;
      end
      StArmWr: begin
        req   = 1'b1;
        we    = 1'b1;
        wdata = arm_word(HOLDOFF);
      end
      StRdBus: begin
        req  = 1'b1;
        addr = AddrData;
      end
      default: ;
    endcase
  end

  wbscope_wbm_single u_wbm (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .req_i      (req),
    .abort_i    (abort),
    .we_i       (we),
    .addr_i     (addr),
    .data_i     (wdata),
    .done_o     (wb_done),
    .rdata_o    (rdata),
    .wb_cyc_o   (bus.o_wb_cyc),
    .wb_stb_o   (bus.o_wb_stb),
    .wb_we_o    (bus.o_wb_we),
    .wb_addr_o  (bus.o_wb_addr),
    .wb_data_o  (bus.o_wb_data),
    .wb_ack_i   (bus.i_wb_ack),
    .wb_stall_i (bus.i_wb_stall),
    .wb_data_i  (bus.i_wb_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= StIdle;
      rd_cnt_q       <= '0;
      tmo_cnt_q      <= 32'h0;
      sample_q       <= 32'h0;
      sample_valid_q <= 1'b0;
      sample_last_q  <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q        <= StIdle;
        sample_valid_q <= 1'b0;
        sample_last_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: if (i_start) state_q <= StRstWr;
          StRstWr: if (wb_done) state_q <= StArmWr;
          StArmWr: begin
            if (wb_done) begin
              state_q   <= StWaitTrig;
              tmo_cnt_q <= 32'h0;
            end
          end
          StWaitTrig: begin
            if (bus.i_scope_int) begin
              state_q  <= StRdBus;
              rd_cnt_q <= '0;
            end else if (TIMEOUT != 32'd0) begin
              if (tmo_cnt_q == TIMEOUT - 32'd1) begin
                err_q   <= 1'b1;
                state_q <= StIdle;
              end else begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
              end
            end
          end
          StRdBus: begin
            if (wb_done) begin
              sample_q       <= rdata;
              sample_valid_q <= 1'b1;
              sample_last_q  <= (rd_cnt_q == LastIdx);
              state_q        <= StRdOut;
            end
          end
          StRdOut: begin
            if (bus.i_sample_ready) begin
              sample_valid_q <= 1'b0;
              sample_last_q  <= 1'b0;
              // Terminal compare rather than wrap: the counter stops at the last word.
              if (rd_cnt_q == LastIdx) begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
                state_q  <= StRdBus;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_busy             = (state_q != StIdle);
  assign o_done             = done_q;
  assign o_err              = err_q;
  assign bus.o_sample_valid = sample_valid_q;
  assign bus.o_sample       = sample_q;
  assign bus.o_sample_last  = sample_last_q;

endmodule

// File: tb/tb_wbscope_reader.sv
// Directed/randomised bench: behavioural wbscope slave and stream sink with a queue scoreboard.
module tb_wbscope_reader;

  localparam int unsigned Lg     = 6;
  localparam int unsigned NWords = 1 << Lg;
  localparam int unsigned Tmo    = 100;

  logic clk, rst_n, start, abort, busy, done, err;

  wbscope_reader_if bus ();

  wbscope_reader #(
    .LGMEM   (Lg),
    .HOLDOFF (20'd16),
    .TIMEOUT (Tmo)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_abort (abort),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  int n_err   = 0;
  int stall_fix = -1;
  int hold_idx  = -1;
  bit sink_stop = 1'b0;
  int bad_addr = 0, wb_unstable = 0, unstable_s = 0, stray_last = 0;

  logic [31:0] wrq[$];
  logic [31:0] rdq[$];
  logic [31:0] gotq[$];
  bit          lastq[$];
  int          stbrun_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scope model: random or fixed stall per strobe, random ack delay, random read data.
  initial begin : slave
    bit          in_req, accepted;
    int          stall_left, ack_wait, stb_run;
    logic        cur_we, cur_addr;
    logic [31:0] cur_data, d;
    in_req = 0; accepted = 0; stall_left = 0; ack_wait = 0; stb_run = 0;
    cur_we = 0; cur_addr = 0; cur_data = 0;
    forever begin
      @(negedge clk);
      bus.i_wb_ack = 1'b0;
      if (!rst_n || !bus.o_wb_cyc) begin
        in_req = 0;
        accepted = 0;
        bus.i_wb_stall = 1'b0;
        if (!rst_n) bus.i_wb_data = 32'h0;
      end else if (bus.o_wb_stb) begin
        if (!in_req) begin
          in_req = 1;
          stb_run = 0;
          cur_we = bus.o_wb_we;
          cur_addr = bus.o_wb_addr;
          cur_data = bus.o_wb_data;
          stall_left = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 2));
        end else if ({bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data} !== {cur_we, cur_addr, cur_data}) begin
          wb_unstable++;
        end
        stb_run++;
        if (stall_left > 0) begin
          bus.i_wb_stall = 1'b1;
          stall_left--;
        end else begin
          bus.i_wb_stall = 1'b0;
          in_req = 0;
          accepted = 1;
          ack_wait = int'($urandom_range(0, 2));
          stbrun_q.push_back(stb_run);
        end
      end else if (accepted) begin
        bus.i_wb_stall = 1'b0;
        if (ack_wait > 0) ack_wait--;
        else begin
          accepted = 0;
          bus.i_wb_ack = 1'b1;
          if (cur_we) begin
            wrq.push_back(cur_data);
            if (cur_addr !== 1'b0) bad_addr++;
          end else begin
            d = $urandom;
            bus.i_wb_data = d;
            rdq.push_back(d);
            if (cur_addr !== 1'b1) bad_addr++;
          end
        end
      end
    end
  end

  // Stream sink: random ready, optional 10-cycle stall at one sample index.
  initial begin : sink
    logic [31:0] prev_sample;
    bit          prev_wait;
    int          hold_cnt;
    prev_sample = 0; prev_wait = 0; hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.i_sample_ready = 1'b0;
        prev_wait = 0;
      end else begin
        if (!busy) hold_cnt = 0;
        if (bus.o_sample_last && !bus.o_sample_valid) stray_last++;
        if (bus.o_sample_valid && prev_wait && bus.o_sample !== prev_sample) unstable_s++;
        if (sink_stop) bus.i_sample_ready = 1'b0;
        else if (bus.o_sample_valid && gotq.size() == hold_idx && hold_cnt < 10) begin
          bus.i_sample_ready = 1'b0;
          hold_cnt++;
        end else bus.i_sample_ready = ($urandom_range(0, 3) != 0);
        if (bus.o_sample_valid && bus.i_sample_ready) begin
          gotq.push_back(bus.o_sample);
          lastq.push_back(bus.o_sample_last);
          prev_wait = 0;
        end else begin
          prev_wait = bus.o_sample_valid;
          prev_sample = bus.o_sample;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_queues();
    wrq.delete(); rdq.delete(); gotq.delete(); lastq.delete(); stbrun_q.delete();
  endtask

  task automatic begin_capture();
    int cnt;
    bus.i_scope_int = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (wrq.size() < 2 && cnt < 500) begin @(negedge clk); cnt++; end
    repeat ($urandom_range(1, 20)) @(negedge clk);
    bus.i_scope_int = 1'b1;
  endtask

  task automatic capture(input string nm, input int stall_mode, input int hold_at);
    int d0, e0, ba0, wu0, us0, sl0, cnt, nbad, nlast, nrun;
    clear_queues();
    d0 = n_done; e0 = n_err; ba0 = bad_addr; wu0 = wb_unstable; us0 = unstable_s; sl0 = stray_last;
    stall_fix = stall_mode;
    hold_idx = hold_at;
    begin_capture();
    cnt = 0;
    while (n_done == d0 && cnt < 5000) begin @(negedge clk); cnt++; end
    repeat (2) @(negedge clk);
    bus.i_scope_int = 1'b0;
    check({nm, "/done_pulses"}, n_done - d0, 1);
    check({nm, "/err_pulses"}, n_err - e0, 0);
    check({nm, "/writes"}, wrq.size(), 2);
    check({nm, "/wr_reset"}, (wrq.size() > 0) ? wrq[0] : 32'hdead_beef, 32'h0000_0000);
    check({nm, "/wr_arm"}, (wrq.size() > 1) ? wrq[1] : 32'hdead_beef, 32'h8000_0010);
    check({nm, "/reads"}, rdq.size(), NWords);
    check({nm, "/samples"}, gotq.size(), NWords);
    nbad = 0;
    for (int i = 0; i < gotq.size() && i < rdq.size(); i++) if (gotq[i] !== rdq[i]) nbad++;
    check({nm, "/data_mismatch"}, nbad, 0);
    nlast = 0;
    foreach (lastq[i]) if (lastq[i]) nlast++;
    check({nm, "/last_count"}, nlast, 1);
    check({nm, "/last_pos"}, (lastq.size() == NWords) ? lastq[NWords-1] : 1'b0, 1);
    check({nm, "/bad_addr"}, bad_addr - ba0, 0);
    check({nm, "/wb_unstable"}, wb_unstable - wu0, 0);
    check({nm, "/sample_unstable"}, unstable_s - us0, 0);
    check({nm, "/stray_last"}, stray_last - sl0, 0);
    check({nm, "/idle"}, busy, 0);
    if (stall_mode == 3) begin
      nrun = 0;
      foreach (stbrun_q[i]) if (stbrun_q[i] != 4) nrun++;
      check({nm, "/stb_len"}, nrun, 0);
      check({nm, "/strobes"}, stbrun_q.size(), NWords + 2);
    end
    stall_fix = -1;
    hold_idx = -1;
  endtask

  initial begin : main
    int cnt, d0, e0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.i_scope_int = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/ctrl", {busy, done, err, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we,
                         bus.o_wb_addr, bus.o_sample_valid, bus.o_sample_last}, 0);
    check("reset/wdata", bus.o_wb_data, 0);
    check("reset/sample", bus.o_sample, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset/idle_after_release", {busy, bus.o_wb_cyc}, 0);

    capture("basic", -1, -1);
    capture("ready_hold", -1, 20);
    capture("stall3", 3, -1);

    // Timeout with no trigger.
    clear_queues();
    d0 = n_done; e0 = n_err;
    bus.i_scope_int = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!(wrq.size() >= 2 && !bus.o_wb_cyc) && cnt < 200) begin @(negedge clk); cnt++; end
    cnt = 1;
    while (err !== 1'b1 && cnt < 300) begin @(negedge clk); cnt++; end
    check("tmo/err_cycle", cnt, Tmo + 1);
    check("tmo/idle_with_err", busy, 0);
    @(negedge clk);
    check("tmo/err_pulses", n_err - e0, 1);
    check("tmo/reads", rdq.size(), 0);
    check("tmo/done_pulses", n_done - d0, 0);

    // Abort with a read strobe stalled on the bus.
    clear_queues();
    d0 = n_done; e0 = n_err;
    begin_capture();
    cnt = 0;
    while (rdq.size() < 5 && cnt < 500) begin @(negedge clk); cnt++; end
    stall_fix = 1000;
    cnt = 0;
    while (!(bus.o_wb_cyc && bus.o_wb_stb && !bus.o_wb_we) && cnt < 100) begin
      @(negedge clk); cnt++;
    end
    check("abort/stb_pending", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b11);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort/bus_dropped", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_sample_valid}, 0);
    check("abort/idle", busy, 0);
    repeat (3) @(negedge clk);
    check("abort/no_done_err", (n_done - d0) + (n_err - e0), 0);
    check("abort/bus_quiet", {bus.o_wb_cyc, bus.o_wb_stb}, 0);
    stall_fix = -1;
    capture("post_abort", -1, -1);

    // Asynchronous reset while a sample waits for ready.
    clear_queues();
    begin_capture();
    cnt = 0;
    while (gotq.size() < 3 && cnt < 1000) begin @(negedge clk); cnt++; end
    sink_stop = 1'b1;
    cnt = 0;
    while (bus.o_sample_valid !== 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
    check("rst/pre_valid", bus.o_sample_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst/ctrl", {busy, done, err, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we,
                       bus.o_wb_addr, bus.o_sample_valid, bus.o_sample_last}, 0);
    check("rst/wdata", bus.o_wb_data, 0);
    check("rst/sample", bus.o_sample, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sink_stop = 1'b0;
    bus.i_scope_int = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/idle_after_release", {busy, bus.o_wb_cyc, bus.o_wb_stb}, 0);
    capture("post_reset", -1, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
